// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned-binary converter using reverse double-dabble.
// The converter shifts one bit per clock and reports out-of-range digits as an error.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CAT_W = BCD_W + BIN_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [BCD_W-1:0]   bcd_r, bcd_s;
    logic [BIN_W-1:0]   bin_r, bin_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [BIN_W-1:0]   bin_out_r, bin_out_s;
    logic               error_r, error_s;
    logic [CAT_W-1:0]   step_s;
    logic               last_s;
    logic               bad_s;

    // True when any packed digit is outside 0..9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then correct every digit that became >= 8.
    function automatic logic [CAT_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic [BIN_W-1:0] bin);
        logic [CAT_W-1:0] cat;
        logic [3:0]       nib;
        cat = {1'b0, bcd, bin[BIN_W-1:1]};
        for (int i = 0; i < DIGITS; i++) begin
            nib = cat[BIN_W + 4*i +: 4];
            if (nib >= 4'd8) begin
                cat[BIN_W + 4*i +: 4] = nib - 4'd3;
            end else begin
                cat[BIN_W + 4*i +: 4] = nib;
            end
        end
        return cat;
    endfunction

    assign step_s = dabble_step(bcd_r, bin_r);
    assign last_s = (cnt_r == CNT_W'(BIN_W - 1));
    assign bad_s  = has_bad_digit(bcd_in);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an invalid request never leaves IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !bad_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of datapath and output registers; done defaults low every cycle.
    always_comb begin
        bcd_s     = bcd_r;
        bin_s     = bin_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        bin_out_s = bin_out_r;
        error_s   = error_r;
        case (state_r)
            ST_IDLE: begin
                if (start && bad_s) begin
                    error_s   = 1'b1;
                    bin_out_s = '0;
                    done_s    = 1'b1;
                end else if (start) begin
                    bcd_s   = bcd_in;
                    bin_s   = '0;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                    error_s = 1'b0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                {bcd_s, bin_s} = step_s;
                cnt_s          = cnt_r + CNT_W'(1);
                if (last_s) begin
                    bin_out_s = step_s[BIN_W-1:0];
                    done_s    = 1'b1;
                    busy_s    = 1'b0;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r     <= '0;
            bin_r     <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bin_out_r <= '0;
            error_r   <= 1'b0;
        end else begin
            bcd_r     <= bcd_s;
            bin_r     <= bin_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            bin_out_r <= bin_out_s;
            error_r   <= error_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bin_out = bin_out_r;
    assign error   = error_r;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results, a monitor
// pops and compares value, error flag and arrival cycle on every done pulse.
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    bin_out;
    logic                error;

    typedef struct {
        int bin;
        int err;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .error   (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act == want) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 bin_out=%0d expected no done (cycle %0d)",
                         bin_out, cyc);
            end else begin
                e = q.pop_front();
                chk("bin_out", int'(bin_out), e.bin);
                chk("error", int'(error), e.err);
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", int'(busy), 0);
            end
        end
    end

    // Issue one request at a negedge; returns at the first negedge where a new start is accepted.
    task automatic issue(input logic [7:0] bcd, input int want_bin, input int want_err,
                         input bit hold);
        int e_cyc;
        start  = 1'b1;
        bcd_in = bcd;
        e_cyc  = cyc + 1;
        q.push_back('{want_bin, want_err, (want_err != 0) ? e_cyc : e_cyc + BIN_W});
        @(negedge clk);
        chk("busy_after_accept", int'(busy), (want_err != 0) ? 0 : 1);
        if (!hold) start = 1'b0;
        if (want_err == 0) repeat (BIN_W) @(negedge clk);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_error", int'(error), 0);
        rst = 1'b0;
        idle(2);

        // Basic conversions, including the extremes.
        issue(8'h15, 15, 0, 1'b0);
        idle(3);
        issue(8'h99, 99, 0, 1'b0);
        issue(8'h00, 0, 0, 1'b0);
        idle(2);

        // Invalid digit, then a valid request right after.
        issue(8'h1A, 0, 1, 1'b0);
        chk("error_held", int'(error), 1);
        issue(8'h42, 42, 0, 1'b0);
        issue(8'hA0, 0, 1, 1'b0);
        issue(8'hF5, 0, 1, 1'b0);
        issue(8'h07, 7, 0, 1'b0);
        idle(2);

        // A start pulse during a conversion must be ignored.
        start  = 1'b1;
        bcd_in = 8'h36;
        q.push_back('{36, 0, cyc + 1 + BIN_W});
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h77;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 8'h00;
        idle(12);

        // Reset in the middle of a conversion aborts it without a done pulse.
        start  = 1'b1;
        bcd_in = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bin_out", int'(bin_out), 0);
        chk("abort_error", int'(error), 0);
        idle(12);
        issue(8'h27, 27, 0, 1'b0);
        idle(2);

        // Start held high: one result every BIN_W+1 cycles.
        for (int k = 0; k < 4; k++) issue(8'h58, 58, 0, 1'b1);
        idle(3);

        // Sweep every valid two-digit input.
        for (int d = 0; d < 100; d++) begin
            logic [3:0] tens;
            logic [3:0] units;
            tens  = 4'(d / 10);
            units = 4'(d % 10);
            issue({tens, units}, d, 0, 1'b0);
        end

        idle(12);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
